page_tbl_lookup: RTL and testbench

Parametrised page table with per-entry valid tracking, a hardware clear sweep, and a handshaked lookup port. It sits between the control-path writer and the packet-cache lookup logic in the Menshen pipeline. It generalises the fixed 16-bit × 32-entry page table to any width and depth. Added behaviour: hit/miss reporting, invalidation, write-to-read bypass, backpressure and a miss counter.

---
 rtl/page_tbl_lookup_if.sv | 42 ++++
 rtl/page_tbl_lookup.sv | 165 ++++++++++++++++
 tb/tb_page_tbl_lookup.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/page_tbl_lookup_if.sv
// Bus bundle for page_tbl_lookup: control-path write/clear port, lookup
// request port, registered result port and the miss counter.
// The master side is the table user; the slave side is the table itself.
interface page_tbl_if #(
    parameter int ADDR_BITS = 5,
    parameter int DATA_BITS = 16,
    parameter int CNT_BITS  = 16
);
    // Write / invalidate / clear port
    logic                 wr_en;
    logic                 wr_inval;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [DATA_BITS-1:0] wr_data;
    logic                 clr_req;
    logic                 busy;

    // Lookup request
    logic                 lk_valid;
    logic [ADDR_BITS-1:0] lk_addr;
    logic                 lk_ready;

    // Lookup result
    logic                 res_valid;
    logic                 res_ready;
    logic [DATA_BITS-1:0] res_data;
    logic                 res_hit;

    // Statistics
    logic [CNT_BITS-1:0]  miss_cnt;

    modport master (
        output wr_en, wr_inval, wr_addr, wr_data, clr_req,
        output lk_valid, lk_addr, res_ready,
        input  busy, lk_ready, res_valid, res_data, res_hit, miss_cnt
    );

    modport slave (
        input  wr_en, wr_inval, wr_addr, wr_data, clr_req,
        input  lk_valid, lk_addr, res_ready,
        output busy, lk_ready, res_valid, res_data, res_hit, miss_cnt
    );
endinterface

// File: rtl/page_tbl_lookup.sv
// Parametrised page table with per-entry valid bit, hardware clear sweep,
// handshaked single-cycle lookup with write-to-read bypass, and a saturating
// counter of delivered miss results.
//
// Each RAM word is {valid, payload}. The RAM has one write port (shared by the
// sweep and the control-path writer, never both in the same cycle because
// writes are only honoured in IDLE) and one registered read port that is
// enabled only when a lookup is accepted, so the read register doubles as the
// result holding register under backpressure.
module page_tbl_lookup #(
    parameter int ADDR_BITS = 5,
    parameter int DATA_BITS = 16,
    parameter int CNT_BITS  = 16
) (
    input  logic     clk,
    input  logic     rst,
    page_tbl_if.slave bus
);
    localparam int DEPTH      = 1 << ADDR_BITS;
    localparam int ENTRY_BITS = DATA_BITS + 1;

    typedef enum logic [0:0] {
        ST_SWEEP = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_BITS-1:0]  ptr_reg, ptr_next;

    // RAM write port, driven by the FSM process
    logic                  mem_we;
    logic [ADDR_BITS-1:0]  mem_waddr;
    logic [ENTRY_BITS-1:0] mem_wdata;

    logic [ENTRY_BITS-1:0] mem [DEPTH];
    logic [ENTRY_BITS-1:0] rd_q_reg;

    // Result path
    logic                  res_valid_reg;
    logic                  byp_sel_reg;
    logic [ENTRY_BITS-1:0] byp_entry_reg;
    logic [CNT_BITS-1:0]   miss_cnt_reg;

    logic                  busy;
    logic                  wr_fire;
    logic                  lk_ready;
    logic                  lk_fire;
    logic                  res_fire;
    logic                  byp_hit;
    logic                  res_hit;
    logic [ENTRY_BITS-1:0] entry_sel;
    wire  [DATA_BITS-1:0]  res_data_w;

    assign busy     = (state_reg == ST_SWEEP);
    assign wr_fire  = (state_reg == ST_IDLE) & bus.wr_en;
    // A new lookup may enter when the table is available and the result
    // register is either empty or being emptied this cycle.
    assign lk_ready = ~busy & (~res_valid_reg | bus.res_ready);
    assign lk_fire  = bus.lk_valid & lk_ready;
    assign res_fire = res_valid_reg & bus.res_ready;
    // Same-cycle write to the looked-up entry: the RAM read would return the
    // old word, so the new word is captured alongside and selected instead.
    assign byp_hit  = wr_fire & (bus.wr_addr == bus.lk_addr);

    // State and sweep pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_SWEEP;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    // Next state, sweep pointer and RAM write-port selection
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        mem_we     = 1'b0;
        mem_waddr  = bus.wr_addr;
        mem_wdata  = '0;
        case (state_reg)
            ST_SWEEP: begin
                // One entry erased per cycle; clr_req and writes are ignored.
                mem_we    = 1'b1;
                mem_waddr = ptr_reg;
                mem_wdata = '0;
                ptr_next  = ptr_reg + 1'b1;
                if (ptr_reg == ADDR_BITS'(DEPTH - 1)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.wr_en) begin
                    mem_we    = 1'b1;
                    mem_wdata = bus.wr_inval ? '0 : {1'b1, bus.wr_data};
                end
                // A write in the clr_req cycle still lands; the sweep then
                // erases it along with everything else.
                if (bus.clr_req) begin
                    state_next = ST_SWEEP;
                    ptr_next   = '0;
                end
            end
            default: begin
                state_next = ST_SWEEP;
                ptr_next   = '0;
            end
        endcase
    end

    // RAM: write port plus read port registered on lookup acceptance
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (lk_fire) begin
            rd_q_reg <= mem[bus.lk_addr];
        end
    end

    // Result valid flag and bypass capture
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_reg <= 1'b0;
            byp_sel_reg   <= 1'b0;
            byp_entry_reg <= '0;
        end else if (lk_fire) begin
            res_valid_reg <= 1'b1;
            byp_sel_reg   <= byp_hit;
            byp_entry_reg <= mem_wdata;
        end else if (res_fire) begin
            res_valid_reg <= 1'b0;
        end
    end

    // Saturating count of miss results handed to the consumer
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cnt_reg <= '0;
        end else if (res_fire && !res_hit && (miss_cnt_reg != {CNT_BITS{1'b1}})) begin
            miss_cnt_reg <= miss_cnt_reg + 1'b1;
        end
    end

    assign entry_sel = byp_sel_reg ? byp_entry_reg : rd_q_reg;
    assign res_hit   = res_valid_reg & entry_sel[DATA_BITS];

    // Payload is forced to zero on a miss (and while no result is held),
    // whatever stale payload the word carries.
    generate
        for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_res_mask
            assign res_data_w[gi] = entry_sel[gi] & res_hit;
        end
    endgenerate

    assign bus.busy      = busy;
    assign bus.lk_ready  = lk_ready;
    assign bus.res_valid = res_valid_reg;
    assign bus.res_hit   = res_hit;
    assign bus.res_data  = res_data_w;
    assign bus.miss_cnt  = miss_cnt_reg;

endmodule

// File: tb/tb_page_tbl_lookup.sv
// Scoreboard bench for page_tbl_lookup. The driver pushes the expected
// {hit, data} of each accepted lookup; an independent monitor compares every
// presented result against the queue head and pops on handshake. A second
// instance with a 4-bit miss counter sees identical stimulus to cover
// counter saturation.
module tb_page_tbl_lookup;
    localparam int AB = 5;
    localparam int DB = 16;
    localparam int CB = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    page_tbl_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .CNT_BITS(CB)) bif ();
    page_tbl_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .CNT_BITS(4))  sif ();

    assign sif.wr_en     = bif.wr_en;
    assign sif.wr_inval  = bif.wr_inval;
    assign sif.wr_addr   = bif.wr_addr;
    assign sif.wr_data   = bif.wr_data;
    assign sif.clr_req   = bif.clr_req;
    assign sif.lk_valid  = bif.lk_valid;
    assign sif.lk_addr   = bif.lk_addr;
    assign sif.res_ready = bif.res_ready;

    page_tbl_lookup #(.ADDR_BITS(AB), .DATA_BITS(DB), .CNT_BITS(CB)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    page_tbl_lookup #(.ADDR_BITS(AB), .DATA_BITS(DB), .CNT_BITS(4)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    logic [DB:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int model_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every presented result, pop on handshake
    always @(negedge clk) begin
        if (!rst && bif.res_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got hit=%0d data=0x%0h, expected no result",
                         bif.res_hit, bif.res_data);
            end else begin
                chk("res_hit", 32'(bif.res_hit), 32'(exp_q[0][DB]));
                chk("res_data", 32'(bif.res_data), 32'(exp_q[0][DB-1:0]));
                if (bif.res_ready) begin
                    $display("result: hit=%0d data=0x%04h", bif.res_hit, bif.res_data);
                    if (!exp_q[0][DB]) model_miss++;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AB-1:0] addr, input logic [DB-1:0] data, input logic inval);
        bif.wr_en    = 1'b1;
        bif.wr_inval = inval;
        bif.wr_addr  = addr;
        bif.wr_data  = data;
        step();
        bif.wr_en    = 1'b0;
        bif.wr_inval = 1'b0;
    endtask

    task automatic do_lookup(input logic [AB-1:0] addr, input logic hit, input logic [DB-1:0] data);
        logic accepted;
        accepted     = 1'b0;
        bif.lk_valid = 1'b1;
        bif.lk_addr  = addr;
        for (int i = 0; i < 64 && !accepted; i++) begin
            @(negedge clk);
            accepted = bif.lk_ready;
            step();
        end
        bif.lk_valid = 1'b0;
        if (accepted) begin
            exp_q.push_back({hit, data});
        end else begin
            checks++;
            errors++;
            $display("FAIL lookup_accept: addr %0d got no acceptance in 64 cycles, expected acceptance", addr);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        step();
        step();
    endtask

    task automatic check_cnt();
        chk("miss_cnt", 32'(bif.miss_cnt), 32'(model_miss));
        chk("miss_cnt_sat", 32'(sif.miss_cnt), (model_miss > 15) ? 32'd15 : 32'(model_miss));
    endtask

    // busy must stay high for exactly 32 cycles; optionally write every cycle
    task automatic check_sweep(input logic poke);
        for (int k = 0; k < 32; k++) begin
            if (poke) begin
                bif.wr_en   = 1'b1;
                bif.wr_addr = AB'(k);
                bif.wr_data = 16'hDEAD;
            end
            chk("busy_sweep", 32'(bif.busy), 32'd1);
            step();
        end
        bif.wr_en = 1'b0;
        chk("busy_done", 32'(bif.busy), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bif.wr_en     = 1'b0;
        bif.wr_inval  = 1'b0;
        bif.wr_addr   = '0;
        bif.wr_data   = '0;
        bif.clr_req   = 1'b0;
        bif.lk_valid  = 1'b0;
        bif.lk_addr   = '0;
        bif.res_ready = 1'b1;
        repeat (3) step();

        // Reset values
        chk("rst_busy", 32'(bif.busy), 32'd1);
        chk("rst_res_valid", 32'(bif.res_valid), 32'd0);
        chk("rst_res_data", 32'(bif.res_data), 32'd0);
        chk("rst_res_hit", 32'(bif.res_hit), 32'd0);
        chk("rst_miss_cnt", 32'(bif.miss_cnt), 32'd0);
        chk("rst_lk_ready", 32'(bif.lk_ready), 32'd0);
        rst = 1'b0;
        check_sweep(1'b0);
        chk("idle_lk_ready", 32'(bif.lk_ready), 32'd1);

        // Freshly cleared table: every entry misses
        for (int i = 0; i < 32; i++) do_lookup(AB'(i), 1'b0, 16'h0000);
        drain();
        check_cnt();

        // Write then read, invalidate then read
        do_write(5'd5, 16'hBEEF, 1'b0);
        do_lookup(5'd5, 1'b1, 16'hBEEF);
        do_write(5'd5, 16'h0000, 1'b1);
        do_lookup(5'd5, 1'b0, 16'h0000);

        // Same-cycle write/lookup bypass, data then invalidate
        bif.wr_en = 1'b1; bif.wr_inval = 1'b0; bif.wr_addr = 5'd7; bif.wr_data = 16'h1234;
        do_lookup(5'd7, 1'b1, 16'h1234);
        bif.wr_inval = 1'b1;
        do_lookup(5'd7, 1'b0, 16'h0000);
        bif.wr_en = 1'b0; bif.wr_inval = 1'b0;
        drain();

        // Backpressure: three lookups with the consumer stalled
        do_write(5'd1, 16'h1111, 1'b0);
        do_write(5'd2, 16'h2222, 1'b0);
        do_write(5'd3, 16'h3333, 1'b0);
        bif.res_ready = 1'b0;
        fork
            begin
                do_lookup(5'd1, 1'b1, 16'h1111);
                do_lookup(5'd2, 1'b1, 16'h2222);
                do_lookup(5'd3, 1'b1, 16'h3333);
            end
            begin
                step();
                for (int k = 0; k < 3; k++) begin
                    chk("stall_lk_ready", 32'(bif.lk_ready), 32'd0);
                    step();
                end
                bif.res_ready = 1'b1;
            end
        join
        drain();
        check_cnt();

        // Clear sweep with a lookup and a write in the clr_req cycle
        for (int i = 0; i < 32; i++) do_write(AB'(i), 16'hA000 + 16'(i), 1'b0);
        bif.clr_req = 1'b1;
        bif.wr_en = 1'b1; bif.wr_addr = 5'd10; bif.wr_data = 16'h5555;
        do_lookup(5'd4, 1'b1, 16'hA004);
        bif.clr_req = 1'b0;
        bif.wr_en = 1'b0;
        check_sweep(1'b1);
        for (int i = 0; i < 32; i++) do_lookup(AB'(i), 1'b0, 16'h0000);
        drain();
        check_cnt();

        // Reset while a result is stalled
        bif.res_ready = 1'b0;
        do_lookup(5'd3, 1'b0, 16'h0000);
        step();
        rst = 1'b1;
        step();
        exp_q.delete();
        model_miss = 0;
        chk("rst_stall_res_valid", 32'(bif.res_valid), 32'd0);
        chk("rst_stall_busy", 32'(bif.busy), 32'd1);
        check_cnt();
        bif.res_ready = 1'b1;
        rst = 1'b0;
        check_sweep(1'b0);
        do_write(5'd3, 16'h7777, 1'b0);
        do_lookup(5'd3, 1'b1, 16'h7777);
        do_lookup(5'd8, 1'b0, 16'h0000);
        drain();
        check_cnt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
